fifo_rd_ctrl: RTL and testbench

Read-side controller for the dual-clock FIFO. It runs entirely in the read clock domain and:
- synchronizes the write pointer and keeps the read pointer;
- generates the empty flag, read address and read enable for the FIFO memory;
- turns the memory's one-cycle registered read into a valid/ready output stream with full throughput and no word loss under backpressure.

---
 rtl/fifo_rd_ctrl.sv | 84 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of a dual-clock FIFO, entirely in the rclk domain.
//   Synchronizes the write pointer and keeps the read pointer.
//   Produces the empty flag plus the read address and read enable for the memory.
//   Converts the memory's one-cycle registered read into a valid/ready stream.
//   The stream runs at full throughput and loses no word under backpressure.
// Ports:
//   rclk, rrst       clock; asynchronous active-high reset
//   wptr_gray        Gray write pointer from the write domain (unsynchronized)
//   rptr_gray        registered Gray read pointer, to the write-domain synchronizer
//   raddr, rclken    memory read address / read enable
//   rempty           registered empty flag
//   mem_rdata        registered memory read data (stage 1)
//   dout, dout_valid output word and its valid flag (stage 2)
//   dout_ready       downstream accepts dout this cycle
//   rlevel           words in memory not yet fetched (pipeline excluded)
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  output logic                rempty,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [ADDRSIZE:0]   rlevel
);

  logic [ADDRSIZE:0] rq1, rq2;
  logic [ADDRSIZE:0] rbin, rbinnext, rgraynext, wbin_s;
  logic              s1_v, adv, fetch;

  always_comb begin
    // Stage 1 moves into dout when dout is empty or being consumed.
    adv       = s1_v && (!dout_valid || dout_ready);
    // Fetch only when stage 1 will be free at the next edge.
    fetch     = !rempty && (!s1_v || adv);
    rbinnext  = rbin + {{ADDRSIZE{1'b0}}, fetch};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(rq2 >> i);
    end
  end

  assign raddr  = rbin[ADDRSIZE-1:0];
  assign rclken = fetch;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1        <= '0;
      rq2        <= '0;
      rbin       <= '0;
      rptr_gray  <= '0;
      rempty     <= 1'b1;
      s1_v       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      rlevel     <= '0;
    end else begin
      rq1       <= wptr_gray;
      rq2       <= rq1;
      rbin      <= rbinnext;
      rptr_gray <= rgraynext;
      // Compare against the post-fetch pointer so the last fetch sets empty on the same edge.
      rempty    <= (rgraynext == rq2);
      s1_v      <= fetch | (s1_v & ~adv);
      if (adv) begin
        dout       <= mem_rdata;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      rlevel    <= wbin_s - rbinnext;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [AW:0]   wptr_gray = '0;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          rclken;
  logic          rempty;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [AW:0]   rlevel;

  int checks = 0;
  int errors = 0;
  int run = 0;

  // Write-side model: memory contents, binary write count, expected output order.
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wbin = '0;
  logic [DW-1:0] exp_q [$];

  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wptr_gray), .rptr_gray(rptr_gray),
    .raddr(raddr), .rclken(rclken), .rempty(rempty), .mem_rdata(mem_rdata),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .rlevel(rlevel)
  );

  always #5 rclk = ~rclk;

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int i = 1; i <= AW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory with registered read, as seen by the controller.
  always @(posedge rclk) begin
    if (rclken && !rempty) mem_rdata <= mem[raddr];
  end

  // Monitor: pops the scoreboard on every handshake, checks dout holds while stalled.
  logic          stall_seen = 1'b0;
  logic [DW-1:0] stall_word = '0;
  always @(negedge rclk) begin
    if (rrst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_hold", dout, stall_word);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%0h required=none at %0t", dout, $time);
        end else begin
          chk("dout_data", dout, exp_q.pop_front());
        end
      end
      stall_seen = dout_valid && !dout_ready;
      stall_word = dout;
    end
  end

  // Called #1 after a rising edge; performs one write-side write without advancing time
  // unless the memory is full.
  task automatic write_word(input logic [DW-1:0] d);
    int guard;
    logic [AW:0] used;
    guard = 0;
    used = wbin - gray2bin(rptr_gray);
    while (used >= DEPTH && guard < 200) begin
      @(posedge rclk); #1;
      guard++;
      used = wbin - gray2bin(rptr_gray);
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL write_space actual=full required=space at %0t", $time);
    end
    mem[wbin[AW-1:0]] = d;
    wbin = wbin + 1'b1;
    wptr_gray = bin2gray(wbin);
    exp_q.push_back(d);
  endtask

  task automatic drain(input string name);
    int guard;
    dout_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || dout_valid) && guard < 300) begin
      @(posedge rclk); #1;
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual=%0d_left required=0 at %0t", name, exp_q.size(), $time);
    end
    repeat (3) @(posedge rclk);
    #1;
    chk({name, "_rempty"}, rempty, 1);
    chk({name, "_rlevel"}, rlevel, 0);
    chk({name, "_rptr"}, rptr_gray, bin2gray(wbin));
    chk({name, "_rclken"}, rclken, 0);
  endtask

  task automatic do_reset();
    @(posedge rclk); #2;
    rrst = 1'b1;
    wbin = '0;
    wptr_gray = '0;
    exp_q.delete();
    @(posedge rclk);
    @(posedge rclk); #1;
    rrst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge rclk);
    #1 rrst = 1'b0;

    // Reset asserted mid-cycle while the write pointer is non-zero.
    wptr_gray = 5'd3;
    repeat (3) @(posedge rclk);
    #2 rrst = 1'b1;
    #1;
    chk("rst_rptr", rptr_gray, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rclken", rclken, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rlevel", rlevel, 0);
    wptr_gray = '0;
    @(posedge rclk); #1;
    rrst = 1'b0;
    wbin = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge rclk); #1;
      chk("idle_rempty", rempty, 1);
      chk("idle_rclken", rclken, 0);
    end

    // Single word: dout_valid rises exactly 5 edges after the pointer change.
    dout_ready = 1'b1;
    write_word(8'hA5);
    for (int e = 0; e <= 4; e++) begin
      @(posedge rclk); #1;
      chk("one_rclken", rclken, (e == 2) ? 1 : 0);
      chk("one_valid", dout_valid, (e == 4) ? 1 : 0);
      if (e == 2) chk("one_rlevel", rlevel, 1);
    end
    chk("one_dout", dout, 8'hA5);
    chk("one_rempty", rempty, 1);
    chk("one_rptr", rptr_gray, 1);
    drain("one");

    // Burst of 16 words with dout_ready held high: no bubbles.
    do_reset();
    dout_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          write_word(i[DW-1:0]);
          @(posedge rclk); #1;
        end
      end
      begin
        run = 0;
        for (int c = 0; c < 100 && !dout_valid; c++) begin
          @(posedge rclk); #1;
        end
        while (dout_valid && run < 40) begin
          run++;
          @(posedge rclk); #1;
        end
      end
    join
    chk("burst_run", run, 16);
    drain("burst");
    chk("burst_rptr16", rptr_gray, 5'h18);

    // Backpressure: four words, downstream stalled for 10 cycles.
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_word(8'h40 + i[DW-1:0]);
      @(posedge rclk); #1;
    end
    repeat (10) @(posedge rclk);
    #1;
    chk("bp_valid", dout_valid, 1);
    chk("bp_dout", dout, exp_q[0]);
    chk("bp_rclken", rclken, 0);
    chk("bp_rlevel", rlevel, 2);
    chk("bp_rempty", rempty, 0);
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge rclk); #1;
      chk("bp_resume", dout_valid, 1);
    end
    drain("bp");

    // Wrap-around: 40 random words in batches, random stalls and write gaps.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        dout_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge rclk); #1;
        end
        write_word(DW'($urandom));
        @(posedge rclk); #1;
      end
      drain("wrap");
    end

    // Reset with 5 words pending.
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_word(8'hC0 + i[DW-1:0]);
      @(posedge rclk); #1;
    end
    repeat (3) @(posedge rclk);
    #2 rrst = 1'b1;
    wbin = '0;
    wptr_gray = '0;
    exp_q.delete();
    #1;
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_rlevel", rlevel, 0);
    chk("mrst_rempty", rempty, 1);
    @(posedge rclk);
    @(posedge rclk); #1;
    rrst = 1'b0;
    chk("mrst_raddr", raddr, 0);
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_word(8'hD0 + i[DW-1:0]);
      @(posedge rclk); #1;
    end
    drain("mrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
